pll_reconfig_seq: RTL and testbench



---
 rtl/pll_reconfig_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// Dynamic PLL preset sequencer: runs the mode/N/M/C0/start write sequence, polls status, then waits for lock.
// Optional feature macro PLL_RECFG_RETRY_EN: one automatic full-sequence retry after a lock timeout.
module pll_reconfig_seq #(
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned POLL_LIMIT   = 4096
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_sel,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  cur_sel,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    output logic        mgmt_read,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_MODE      = 4'd1,
        S_WR_N      = 4'd2,
        S_WR_M      = 4'd3,
        S_WR_C      = 4'd4,
        S_START     = 4'd5,
        S_POLL      = 4'd6,
        S_WAIT_LOCK = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    localparam logic [5:0]  ADDR_MODE   = 6'h00;
    localparam logic [5:0]  ADDR_STATUS = 6'h01;
    localparam logic [5:0]  ADDR_START  = 6'h02;
    localparam logic [5:0]  ADDR_N      = 6'h03;
    localparam logic [5:0]  ADDR_M      = 6'h04;
    localparam logic [5:0]  ADDR_C      = 6'h05;
    localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 32'd1);
    localparam logic [15:0] POLL_LAST   = 16'(POLL_LIMIT - 32'd1);

    function automatic logic [31:0] c0_word(input logic [1:0] sel);
        case (sel)
            2'd0:    c0_word = 32'h0000_0303;
            2'd1:    c0_word = 32'h0000_0202;
            2'd2:    c0_word = 32'h0000_0606;
            2'd3:    c0_word = 32'h0000_0404;
            default: c0_word = 32'h0000_0303;
        endcase
    endfunction

    function automatic logic [5:0] addr_of(input state_t st);
        case (st)
            S_MODE:  addr_of = ADDR_MODE;
            S_WR_N:  addr_of = ADDR_N;
            S_WR_M:  addr_of = ADDR_M;
            S_WR_C:  addr_of = ADDR_C;
            S_START: addr_of = ADDR_START;
            S_POLL:  addr_of = ADDR_STATUS;
            default: addr_of = 6'h00;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input state_t st, input logic [1:0] sel);
        case (st)
            S_MODE:  data_of = 32'h0000_0001;
            S_WR_N:  data_of = 32'h0001_0000;
            S_WR_M:  data_of = 32'h0000_0606;
            S_WR_C:  data_of = c0_word(sel);
            S_START: data_of = 32'h0000_0001;
            default: data_of = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  cur_sel_q, cur_sel_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [19:0] lock_cnt_q, lock_cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [1:0]  lock_sync_q, lock_sync_d;
    logic        retry_q, retry_d;
    logic        gap_s;
    logic        wr_done_s;
    logic        rd_done_s;
    logic        unused_readdata_s;

    assign wr_done_s         = wr_q && !mgmt_waitrequest;
    assign rd_done_s         = rd_q && !mgmt_waitrequest;
    assign unused_readdata_s = ^mgmt_readdata[31:1];

    // Next-state, handshake and registered-output decode
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cur_sel_d  = cur_sel_q;
        err_d      = err_q;
        done_d     = 1'b0;
        lock_cnt_d = lock_cnt_q;
        poll_cnt_d = poll_cnt_q;
        retry_d    = retry_q;
        gap_s      = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (req_valid && ready_q) begin
                    state_d = S_MODE;
                    sel_d   = req_sel;
                    err_d   = 1'b0;
                    retry_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_MODE: begin
                if (wr_done_s) state_d = S_WR_N;
                else           state_d = state_q;
            end
            S_WR_N: begin
                if (wr_done_s) state_d = S_WR_M;
                else           state_d = state_q;
            end
            S_WR_M: begin
                if (wr_done_s) state_d = S_WR_C;
                else           state_d = state_q;
            end
            S_WR_C: begin
                if (wr_done_s) state_d = S_START;
                else           state_d = state_q;
            end
            S_START: begin
                if (wr_done_s) begin
                    state_d    = S_POLL;
                    poll_cnt_d = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_POLL: begin
                // A not-ready status inserts one idle cycle before the next read
                if (!rd_done_s) begin
                    state_d = state_q;
                end else if (mgmt_readdata[0]) begin
                    state_d    = S_WAIT_LOCK;
                    lock_cnt_d = 20'd0;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    gap_s      = 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_sync_q[1]) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    cur_sel_d = sel_q;
                end else if (lock_cnt_q == LOCK_LAST) begin
`ifdef PLL_RECFG_RETRY_EN
                    if (!retry_q) begin
                        state_d = S_MODE;
                        retry_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
`else
                    state_d = S_ERR;
                    err_d   = 1'b1;
`endif
                end else begin
                    lock_cnt_d = lock_cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_ERR);
        busy_d  = !ready_d;
        wr_d    = (state_d == S_MODE) || (state_d == S_WR_N) || (state_d == S_WR_M) ||
                  (state_d == S_WR_C) || (state_d == S_START);
        rd_d    = (state_d == S_POLL) && !gap_s;
        addr_d  = addr_of(state_d);
        wdata_d = data_of(state_d, sel_d);

        // Lock is only sampled while waiting for it; the chain restarts on every entry
        if (state_d == S_WAIT_LOCK) begin
            lock_sync_d = {lock_sync_q[0], pll_locked};
        end else begin
            lock_sync_d = 2'b00;
        end
    end

    // State and output registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'd0;
            cur_sel_q   <= 2'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 32'h0000_0000;
            lock_cnt_q  <= 20'd0;
            poll_cnt_q  <= 16'd0;
            lock_sync_q <= 2'b00;
            retry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cur_sel_q   <= cur_sel_d;
            err_q       <= err_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lock_cnt_q  <= lock_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            lock_sync_q <= lock_sync_d;
            retry_q     <= retry_d;
        end
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_sel        = cur_sel_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = wdata_q;
    assign mgmt_write     = wr_q;
    assign mgmt_read      = rd_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: table of preset requests plus hand sequences for timeout, overrun and reset.
module tb_pll_reconfig_seq;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_sel;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  cur_sel;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    always #5 refclk = ~refclk;

    pll_reconfig_seq #(.LOCK_TIMEOUT(16), .POLL_LIMIT(8)) dut (
        .refclk(refclk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .busy(busy), .done(done), .err(err), .cur_sel(cur_sel),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

`ifdef PLL_RECFG_RETRY_EN
    localparam int TO_END    = 45;
    localparam int TO_WRITES = 10;
`else
    localparam int TO_END    = 23;
    localparam int TO_WRITES = 5;
`endif

    int checks = 0;
    int errors = 0;

    int          wr_stall     = 0;
    int          status_zeros = 0;
    int          wr_stall_cnt = 0;
    int          rd_done      = 0;
    bit          overlap_err  = 1'b0;
    bit          stab_err     = 1'b0;
    bit          gap_err      = 1'b0;
    bit          stall_pend   = 1'b0;
    bit          prev_rd      = 1'b0;
    logic [5:0]  s_addr;
    logic [31:0] s_data;
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];

    // Slave responder: stalls each write wr_stall cycles, status bit0 rises after status_zeros reads
    always @(posedge refclk) begin
        #1;
        if (mgmt_write && wr_stall_cnt < wr_stall) begin
            mgmt_waitrequest = 1'b1;
            wr_stall_cnt     = wr_stall_cnt + 1;
        end else begin
            mgmt_waitrequest = 1'b0;
            wr_stall_cnt     = 0;
        end
        mgmt_readdata = (rd_done >= status_zeros) ? 32'h0000_0001 : 32'h0000_0000;
    end

    // Bus monitor: logs completed writes, counts reads, flags protocol violations
    always @(posedge refclk) begin
        if (mgmt_write && mgmt_read) overlap_err = 1'b1;
        if (mgmt_write) begin
            if (stall_pend && (mgmt_address !== s_addr || mgmt_writedata !== s_data)) stab_err = 1'b1;
            stall_pend = mgmt_waitrequest;
            s_addr     = mgmt_address;
            s_data     = mgmt_writedata;
            if (!mgmt_waitrequest) begin
                wa_q.push_back(mgmt_address);
                wd_q.push_back(mgmt_writedata);
            end
        end else begin
            stall_pend = 1'b0;
        end
        if (mgmt_read && prev_rd) gap_err = 1'b1;
        prev_rd = mgmt_read && !mgmt_waitrequest;
        if (prev_rd) rd_done = rd_done + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        rd_done  = 0;
        stab_err = 1'b0;
        gap_err  = 1'b0;
    endtask

    // Issue one request; follow it until busy drops (cycle 1 = first cycle after acceptance)
    task automatic run_req(input logic [1:0] sel, input int ign_cyc,
                           output logic busy1, output logic wr1, output logic err1,
                           output int done_cyc, output int done_cnt, output int end_cyc);
        int cyc;
        done_cyc  = 0;
        done_cnt  = 0;
        end_cyc   = 0;
        req_sel   = sel;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        busy1 = busy;
        wr1   = mgmt_write;
        err1  = err;
        cyc   = 1;
        while (cyc < 300 && end_cyc == 0) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) begin
                end_cyc = cyc;
            end else begin
                if (cyc == ign_cyc) begin
                    req_sel   = 2'd3;
                    req_valid = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
                step();
                cyc++;
            end
        end
        req_valid = 1'b0;
        check("run_bounded", (end_cyc != 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [1:0] sel;
        int         stall;
        int         zeros;
        int         exp_done;
        int         exp_reads;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] c0_tab[4];
    logic [5:0]  exp_addr[5];
    logic [31:0] exp_data[5];

    initial begin
        logic b1, w1, e1;
        int   dcyc, dcnt, ecyc;

        vecs[0] = '{sel: 2'd1, stall: 0, zeros: 0, exp_done: 9,  exp_reads: 1};
        vecs[1] = '{sel: 2'd3, stall: 3, zeros: 0, exp_done: 24, exp_reads: 1};
        vecs[2] = '{sel: 2'd2, stall: 1, zeros: 1, exp_done: 16, exp_reads: 2};
        vecs[3] = '{sel: 2'd0, stall: 0, zeros: 3, exp_done: 15, exp_reads: 4};
        c0_tab[0] = 32'h0000_0303;
        c0_tab[1] = 32'h0000_0202;
        c0_tab[2] = 32'h0000_0606;
        c0_tab[3] = 32'h0000_0404;
        exp_addr[0] = 6'h00; exp_data[0] = 32'h0000_0001;
        exp_addr[1] = 6'h03; exp_data[1] = 32'h0001_0000;
        exp_addr[2] = 6'h04; exp_data[2] = 32'h0000_0606;
        exp_addr[3] = 6'h05;
        exp_addr[4] = 6'h02; exp_data[4] = 32'h0000_0001;

        rst_n            = 1'b0;
        req_valid        = 1'b0;
        req_sel          = 2'd0;
        pll_locked       = 1'b1;
        mgmt_waitrequest = 1'b0;
        mgmt_readdata    = 32'h0;
        step();
        step();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_cur",   {30'd0, cur_sel}, 32'd0);
        check("rst_wr_rd", {30'd0, mgmt_write, mgmt_read}, 32'd0);
        check("rst_addr",  {26'd0, mgmt_address}, 32'd0);
        check("rst_wdata", mgmt_writedata, 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            wr_stall     = vecs[v].stall;
            status_zeros = vecs[v].zeros;
            clear_log();
            run_req(vecs[v].sel, 0, b1, w1, e1, dcyc, dcnt, ecyc);
            check($sformatf("v%0d_busy1", v), {31'd0, b1}, 32'd1);
            check($sformatf("v%0d_wr1", v), {31'd0, w1}, 32'd1);
            check($sformatf("v%0d_done_cyc", v), dcyc, vecs[v].exp_done);
            check($sformatf("v%0d_end_cyc", v), ecyc, vecs[v].exp_done);
            check($sformatf("v%0d_cur_sel", v), {30'd0, cur_sel}, {30'd0, vecs[v].sel});
            check($sformatf("v%0d_err", v), {31'd0, err}, 32'd0);
            check($sformatf("v%0d_nwrites", v), wa_q.size(), 32'd5);
            check($sformatf("v%0d_nreads", v), rd_done, vecs[v].exp_reads);
            check($sformatf("v%0d_stable", v), {31'd0, stab_err}, 32'd0);
            check($sformatf("v%0d_rd_gap", v), {31'd0, gap_err}, 32'd0);
            if (wa_q.size() >= 5) begin
                exp_data[3] = c0_tab[vecs[v].sel];
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("v%0d_waddr%0d", v, i), {26'd0, wa_q[i]}, {26'd0, exp_addr[i]});
                    check($sformatf("v%0d_wdata%0d", v, i), wd_q[i], exp_data[i]);
                end
            end
            step();
            check($sformatf("v%0d_done_1cyc", v), {31'd0, done}, 32'd0);
        end

        // Lock never arrives; a sel=3 request while busy must be ignored
        wr_stall     = 0;
        status_zeros = 0;
        pll_locked   = 1'b0;
        clear_log();
        run_req(2'd1, 3, b1, w1, e1, dcyc, dcnt, ecyc);
        check("to_end_cyc", ecyc, TO_END);
        check("to_done_cnt", dcnt, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_ready", {31'd0, req_ready}, 32'd1);
        check("to_cur_sel", {30'd0, cur_sel}, 32'd0);
        check("to_nwrites", wa_q.size(), TO_WRITES);
        if (wa_q.size() >= 4) check("to_c0_word", wd_q[3], 32'h0000_0202);
        step();
        check("to_err_sticky", {31'd0, err}, 32'd1);

        // Recovery from ERR with sel=2
        pll_locked = 1'b1;
        clear_log();
        run_req(2'd2, 0, b1, w1, e1, dcyc, dcnt, ecyc);
        check("rec_err_clr", {31'd0, e1}, 32'd0);
        check("rec_done_cyc", dcyc, 32'd9);
        check("rec_cur_sel", {30'd0, cur_sel}, 32'd2);
        check("rec_err", {31'd0, err}, 32'd0);

        // Lock loss while idle is ignored
        pll_locked = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("idle_lockloss", {28'd0, busy, err, cur_sel}, 32'd2);
        pll_locked = 1'b1;

        // Status never ready: POLL_LIMIT reads then ERR, never retried
        status_zeros = 1000;
        clear_log();
        run_req(2'd3, 0, b1, w1, e1, dcyc, dcnt, ecyc);
        check("ovr_end_cyc", ecyc, 32'd21);
        check("ovr_nreads", rd_done, 32'd8);
        check("ovr_err", {31'd0, err}, 32'd1);
        check("ovr_nwrites", wa_q.size(), 32'd5);
        check("ovr_cur_sel", {30'd0, cur_sel}, 32'd2);
        check("ovr_rd_gap", {31'd0, gap_err}, 32'd0);

        // Reset asserted during WR_M drops the transfer and all later traffic
        status_zeros = 0;
        clear_log();
        req_sel   = 2'd1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("rst_mid_addr", {26'd0, mgmt_address}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {27'd0, req_ready, busy, done, err, mgmt_write}, 32'h10);
        check("rst_mid_rd", {31'd0, mgmt_read}, 32'd0);
        check("rst_mid_cur", {30'd0, cur_sel}, 32'd0);
        check("rst_mid_addr0", {26'd0, mgmt_address}, 32'd0);
        check("rst_mid_wdata", mgmt_writedata, 32'd0);
        step();
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("rst_mid_nwrites", wa_q.size(), 32'd2);
        check("rst_mid_idle", {30'd0, busy, mgmt_write}, 32'd0);

        check("no_wr_rd_overlap", {31'd0, overlap_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
